// File: rtl/hook_draw_scheduler.sv
// hook_draw_scheduler: sequences hook 1 then hook 2 each frame, forwarding clipped pixels to the VGA port
module hook_draw_scheduler #(
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240,
    parameter int TIMEOUT  = 4096
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        frame_start,
    output logic        en1,
    output logic        en2,
    input  logic [8:0]  x1,
    input  logic [8:0]  x2,
    input  logic [7:0]  y1,
    input  logic [7:0]  y2,
    input  logic [11:0] c1,
    input  logic [11:0] c2,
    input  logic        we1,
    input  logic        we2,
    input  logic        done1,
    input  logic        done2,
    output logic [8:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [11:0] vga_colour,
    output logic        vga_plot,
    output logic        busy,
    output logic        frame_done,
    output logic [15:0] pixel_count,
    output logic        timeout_err,
    output logic        overrun_err
);
    typedef enum logic [2:0] {IDLE, START1, RUN1, START2, RUN2, FDONE} state_t;

    localparam logic [8:0]  X_LIM   = 9'(SCREEN_W);
    localparam logic [7:0]  Y_LIM   = 8'(SCREEN_H);
    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [15:0] wd;
    logic        run1, run2, run, we_s, done_s, hit, wd_exp;
    logic [8:0]  x_s;
    logic [7:0]  y_s;
    logic [11:0] c_s;

    assign run1       = state == RUN1;
    assign run2       = state == RUN2;
    assign run        = run1 || run2;
    assign we_s       = run1 ? we1 : run2 ? we2 : 1'b0;
    assign done_s     = run1 ? done1 : run2 ? done2 : 1'b0;
    assign x_s        = run2 ? x2 : x1;
    assign y_s        = run2 ? y2 : y1;
    assign c_s        = run2 ? c2 : c1;
    assign hit        = we_s && (x_s < X_LIM) && (y_s < Y_LIM);
    assign wd_exp     = run && (wd == WD_LAST);
    assign busy       = state != IDLE;
    assign en1        = state == START1;
    assign en2        = state == START2;
    assign frame_done = state == FDONE;

    // next-state decode: each RUN state leaves on its drawer's done or on watchdog expiry
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = frame_start ? START1 : IDLE;
            START1:  state_nx = RUN1;
            RUN1:    state_nx = (done_s || wd_exp) ? START2 : RUN1;
            START2:  state_nx = RUN2;
            RUN2:    state_nx = (done_s || wd_exp) ? FDONE : RUN2;
            FDONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // watchdog counts cycles spent in the current RUN state; START states clear it before entry
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) wd <= '0;
        else         wd <= run ? wd + 16'd1 : '0;
    end

    // registered pixel forwarding; coordinates hold when nothing is plotted
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
        end else begin
            vga_plot <= hit;
            if (hit) begin
                vga_x      <= x_s;
                vga_y      <= y_s;
                vga_colour <= c_s;
            end
        end
    end

    // saturating per-frame pixel counter, cleared when a frame is accepted
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn)                          pixel_count <= '0;
        else if (state == IDLE && frame_start) pixel_count <= '0;
        else if (hit && pixel_count != 16'hFFFF) pixel_count <= pixel_count + 16'd1;
    end

    // sticky error flags: abandoned drawer, and frame requests arriving while busy
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            if (wd_exp && !done_s)             timeout_err <= 1'b1;
            if (frame_start && state != IDLE)  overrun_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hook_draw_scheduler.sv
// tb_hook_draw_scheduler: directed checks of frame sequencing, clipping, watchdog, overrun and reset
module tb_hook_draw_scheduler;
    localparam int TO = 64;

    logic        clock = 1'b0;
    logic        resetn;
    logic        frame_start;
    logic        en1, en2;
    logic [8:0]  x1, x2;
    logic [7:0]  y1, y2;
    logic [11:0] c1, c2;
    logic        we1, we2, done1, done2;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [11:0] vga_colour;
    logic        vga_plot, busy, frame_done, timeout_err, overrun_err;
    logic [15:0] pixel_count;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    hook_draw_scheduler #(.SCREEN_W(320), .SCREEN_H(240), .TIMEOUT(TO)) dut (
        .clock(clock), .resetn(resetn), .frame_start(frame_start),
        .en1(en1), .en2(en2), .x1(x1), .x2(x2), .y1(y1), .y2(y2),
        .c1(c1), .c2(c2), .we1(we1), .we2(we2), .done1(done1), .done2(done2),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .busy(busy), .frame_done(frame_done), .pixel_count(pixel_count),
        .timeout_err(timeout_err), .overrun_err(overrun_err)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0; frame_start = 0;
        x1 = 0; x2 = 0; y1 = 0; y2 = 0; c1 = 0; c2 = 0;
        we1 = 0; we2 = 0; done1 = 0; done2 = 0;
        tick(); tick();
        n_assert++;
        if ({busy, en1, en2, vga_plot, frame_done, timeout_err, overrun_err} !== 7'b0 ||
            vga_x !== 9'd0 || vga_y !== 8'd0 || vga_colour !== 12'd0 || pixel_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b en=%b%b plot=%b fd=%b te=%b oe=%b x=%0d y=%0d c=%0h pc=%0d, expected all 0",
                     busy, en1, en2, vga_plot, frame_done, timeout_err, overrun_err, vga_x, vga_y, vga_colour, pixel_count);
        end
        #3 resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame;
        start_frame();
        n_assert++;
        if (!(busy && en1 && !en2)) begin n_fail++; $display("FAIL basic_start1: busy=%b en1=%b en2=%b, expected 1 1 0", busy, en1, en2); end
        tick();
        n_assert++;
        if (en1 !== 1'b0) begin n_fail++; $display("FAIL basic_en1_width: en1=%b, expected 0", en1); end
        for (int i = 0; i < 10; i++) begin
            we1 = 1; x1 = 9'(10 + i); y1 = 8'(20 + i); c1 = 12'(256 + i);
            tick();
            n_assert++;
            if (vga_plot !== 1'b1 || vga_x !== 9'(10 + i) || vga_y !== 8'(20 + i) || vga_colour !== 12'(256 + i)) begin
                n_fail++;
                $display("FAIL basic_pix1[%0d]: plot=%b x=%0d y=%0d c=%0h, expected 1 %0d %0d %0h", i, vga_plot, vga_x, vga_y, vga_colour, 10 + i, 20 + i, 256 + i);
            end
        end
        we1 = 0; done1 = 1;
        tick();
        done1 = 0;
        n_assert++;
        if (!(en2 && !en1 && !vga_plot)) begin n_fail++; $display("FAIL basic_start2: en1=%b en2=%b plot=%b, expected 0 1 0", en1, en2, vga_plot); end
        tick();
        n_assert++;
        if (en2 !== 1'b0) begin n_fail++; $display("FAIL basic_en2_width: en2=%b, expected 0", en2); end
        for (int i = 0; i < 10; i++) begin
            we2 = 1; x2 = 9'(200 + i); y2 = 8'(100 + i); c2 = 12'(2048 + i);
            tick();
            n_assert++;
            if (vga_plot !== 1'b1 || vga_x !== 9'(200 + i) || vga_y !== 8'(100 + i) || vga_colour !== 12'(2048 + i)) begin
                n_fail++;
                $display("FAIL basic_pix2[%0d]: plot=%b x=%0d y=%0d c=%0h, expected 1 %0d %0d %0h", i, vga_plot, vga_x, vga_y, vga_colour, 200 + i, 100 + i, 2048 + i);
            end
        end
        we2 = 0; done2 = 1;
        tick();
        done2 = 0;
        n_assert++;
        if (!(frame_done && busy)) begin n_fail++; $display("FAIL basic_fdone: frame_done=%b busy=%b, expected 1 1", frame_done, busy); end
        tick();
        n_assert++;
        if (frame_done || busy || pixel_count !== 16'd20) begin
            n_fail++; $display("FAIL basic_end: frame_done=%b busy=%b pc=%0d, expected 0 0 20", frame_done, busy, pixel_count);
        end
    endtask

    task automatic test_clip;
        logic [8:0] xs [4];
        logic [7:0] ys [4];
        xs = '{9'd319, 9'd320, 9'd319, 9'd320};
        ys = '{8'd239, 8'd239, 8'd240, 8'd240};
        start_frame();
        tick();
        for (int i = 0; i < 4; i++) begin
            we1 = 1; x1 = xs[i]; y1 = ys[i]; c1 = 12'(i + 1);
            tick();
            n_assert++;
            if (vga_plot !== (i == 0) || vga_x !== 9'd319 || vga_y !== 8'd239 || vga_colour !== 12'd1) begin
                n_fail++;
                $display("FAIL clip[%0d]: plot=%b x=%0d y=%0d c=%0h, expected %b 319 239 1", i, vga_plot, vga_x, vga_y, vga_colour, i == 0);
            end
        end
        we1 = 0; done1 = 1; tick(); done1 = 0; tick();
        done2 = 1; tick(); done2 = 0; tick();
        n_assert++;
        if (pixel_count !== 16'd1 || busy) begin n_fail++; $display("FAIL clip_count: pc=%0d busy=%b, expected 1 0", pixel_count, busy); end
    endtask

    task automatic test_we_done;
        start_frame();
        tick();
        for (int i = 0; i < 4; i++) begin
            we2 = i[0]; x2 = 9'd5; y2 = 8'd5; c2 = 12'hFFF;
            tick();
            n_assert++;
            if (vga_plot !== 1'b0) begin n_fail++; $display("FAIL we2_in_run1[%0d]: plot=%b, expected 0", i, vga_plot); end
        end
        we2 = 0;
        we1 = 1; done1 = 1; x1 = 9'd7; y1 = 8'd8; c1 = 12'hABC;
        tick();
        we1 = 0; done1 = 0;
        n_assert++;
        if (vga_plot !== 1'b1 || vga_x !== 9'd7 || vga_y !== 8'd8 || vga_colour !== 12'hABC || en2 !== 1'b1) begin
            n_fail++;
            $display("FAIL we_with_done: plot=%b x=%0d y=%0d c=%0h en2=%b, expected 1 7 8 abc 1", vga_plot, vga_x, vga_y, vga_colour, en2);
        end
        tick();
        done2 = 1; tick(); done2 = 0; tick();
        n_assert++;
        if (pixel_count !== 16'd1) begin n_fail++; $display("FAIL we_done_count: pc=%0d, expected 1", pixel_count); end
    endtask

    task automatic test_overrun;
        int fd_count = 0;
        n_assert++;
        if (overrun_err !== 1'b0) begin n_fail++; $display("FAIL overrun_pre: overrun_err=%b, expected 0", overrun_err); end
        start_frame();
        tick();
        frame_start = 1; tick(); frame_start = 0;
        n_assert++;
        if (overrun_err !== 1'b1 || en1 !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL overrun_flag: oe=%b en1=%b busy=%b, expected 1 0 1", overrun_err, en1, busy);
        end
        done1 = 1; tick(); done1 = 0; tick();
        done2 = 1; tick(); done2 = 0;
        for (int i = 0; i < 20; i++) begin
            if (frame_done) fd_count++;
            tick();
        end
        n_assert++;
        if (fd_count != 1 || busy) begin n_fail++; $display("FAIL overrun_single_frame: frame_done pulses=%0d busy=%b, expected 1 0", fd_count, busy); end
    endtask

    task automatic test_timeout;
        int n = 0;
        start_frame();
        tick();
        done1 = 1; tick(); done1 = 0;
        n_assert++;
        if (timeout_err !== 1'b0 || en2 !== 1'b1) begin n_fail++; $display("FAIL timeout_pre: te=%b en2=%b, expected 0 1", timeout_err, en2); end
        tick();
        n = 1;
        for (int i = 0; i < 4 * TO; i++) begin
            tick();
            if (frame_done) break;
            n++;
        end
        n_assert++;
        if (n != TO || frame_done !== 1'b1 || timeout_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_run2: cycles=%0d fd=%b te=%b, expected %0d 1 1", n, frame_done, timeout_err, TO);
        end
        tick();
        start_frame(); tick();
        done1 = 1; tick(); done1 = 0; tick();
        done2 = 1; tick(); done2 = 0;
        n_assert++;
        if (frame_done !== 1'b1 || timeout_err !== 1'b1) begin
            n_fail++; $display("FAIL timeout_sticky: fd=%b te=%b, expected 1 1", frame_done, timeout_err);
        end
        tick();
    endtask

    task automatic test_async_reset;
        int fd_count = 0;
        start_frame(); tick();
        done1 = 1; tick(); done1 = 0; tick();
        we2 = 1; x2 = 9'd33; y2 = 8'd44; c2 = 12'h123;
        tick();
        n_assert++;
        if (vga_plot !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL areset_pre: plot=%b busy=%b, expected 1 1", vga_plot, busy); end
        #2 resetn = 1'b0;
        #1;
        n_assert++;
        if ({busy, en1, en2, vga_plot, frame_done, timeout_err, overrun_err} !== 7'b0 ||
            vga_x !== 9'd0 || vga_y !== 8'd0 || vga_colour !== 12'd0 || pixel_count !== 16'd0) begin
            n_fail++;
            $display("FAIL areset_outputs: busy=%b plot=%b fd=%b te=%b oe=%b x=%0d y=%0d c=%0h pc=%0d, expected all 0",
                     busy, vga_plot, frame_done, timeout_err, overrun_err, vga_x, vga_y, vga_colour, pixel_count);
        end
        we2 = 0;
        @(negedge clock);
        resetn = 1'b1;
        tick();
        start_frame(); tick();
        for (int i = 0; i < 2; i++) begin
            we1 = 1; x1 = 9'(i); y1 = 8'(i); c1 = 12'(i); tick();
        end
        we1 = 0; done1 = 1; tick(); done1 = 0; tick();
        done2 = 1; tick(); done2 = 0;
        for (int i = 0; i < 5; i++) begin
            if (frame_done) fd_count++;
            tick();
        end
        n_assert++;
        if (fd_count != 1 || pixel_count !== 16'd2 || timeout_err || overrun_err || busy) begin
            n_fail++;
            $display("FAIL areset_clean_frame: fd=%0d pc=%0d te=%b oe=%b busy=%b, expected 1 2 0 0 0", fd_count, pixel_count, timeout_err, overrun_err, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_clip();
        test_we_done();
        test_overrun();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/hook_draw_scheduler.md
# hook_draw_scheduler

Frame-level consumer of the two hook drawers' pixel streams. Once per frame it starts hook 1, forwards its pixels to the VGA adapter write port, waits for its `done`, then does the same for hook 2, and finally reports frame completion. It sits between the hook drawers (`draw_hook1`/`draw_hook2` `outX/outY/color/writeEn/done`) and the VGA adapter `x/y/colour/plot` inputs. It adds screen clipping, a pixel counter and a watchdog for drawers that never finish.

## Interface
Parameters:
- `SCREEN_W`, 320: pixels with `x >= SCREEN_W` are clipped.
- `SCREEN_H`, 240: pixels with `y >= SCREEN_H` are clipped.
- `TIMEOUT`, 4096: maximum number of cycles spent in one RUN state before the scheduler forces an advance.

Ports:
- `clock`  in  1  single clock for the block.
- `resetn`  in  1  reset; asynchronous, active-low.
- `frame_start`  in  1  one-cycle pulse requesting that a frame be drawn.
- `en1` / `en2`  out  1  start pulse to hook 1 / hook 2.
- `x1` / `x2`  in  9  drawer X coordinate.
- `y1` / `y2`  in  8  drawer Y coordinate.
- `c1` / `c2`  in  12  drawer colour.
- `we1` / `we2`  in  1  drawer pixel-write strobe.
- `done1` / `done2`  in  1  drawer completion pulse.
- `vga_x`  out  9  X coordinate to the VGA adapter.
- `vga_y`  out  8  Y coordinate to the VGA adapter.
- `vga_colour`  out  12  colour to the VGA adapter.
- `vga_plot`  out  1  VGA adapter write strobe.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `frame_done`  out  1  one-cycle pulse when the frame sequence ends.
- `pixel_count`  out  16  pixels plotted in the current or last frame; saturates.
- `timeout_err`  out  1  sticky flag, set when a drawer is abandoned.
- `overrun_err`  out  1  sticky flag, set when `frame_start` arrives while busy.

## Operation
- FSM states: IDLE, START1, RUN1, START2, RUN2, FDONE.
- IDLE: when `frame_start`=1, go to START1 and clear `pixel_count` to 0.
- START1 lasts 1 cycle; `en1`=1 (Moore decode), then go to RUN1. START2 is the same with `en2`, then RUN2.
  - `en1`/`en2` must be single-cycle: each drawer restarts if `enable` is held high when it returns to its start state.
- RUN1: leave when `done1`=1 or the watchdog expires.
  - On `done1`=1, go to START2.
  - If the watchdog reaches `TIMEOUT-1` first, set `timeout_err` and go to START2.
- RUN2: identical to RUN1 using `done2`; exits to FDONE.
- FDONE lasts 1 cycle; `frame_done`=1, then go to IDLE.
- Watchdog: 16-bit counter, cleared on entry to each RUN state, incremented every cycle spent in that RUN state.
- Pixel forwarding, registered, active only in RUN1 (source 1) and RUN2 (source 2):
  - If the selected `we` is high and `x < SCREEN_W` and `y < SCREEN_H`: `vga_plot`<=1, latch x/y/colour, and `pixel_count` += 1, saturating at 16'hFFFF.
  - Otherwise `vga_plot`<=0 and `vga_x/vga_y/vga_colour` hold their values.
- Inputs from the non-selected drawer are ignored in every state.
- `we` and `done` in the same cycle: the pixel is forwarded and the state still advances.
- A `frame_start` pulse in any state other than IDLE is dropped and sets `overrun_err`.
- `timeout_err` and `overrun_err` clear only on reset.
- Arithmetic: the clip comparisons are unsigned at the input widths (9-bit x, 8-bit y).

## Timing
- Reset (asynchronous, `resetn`=0): state=IDLE and every output is 0, including `vga_x`, `vga_y`, `vga_colour`, `pixel_count` and both sticky flags.
- Reset asserted mid-frame aborts immediately. No `frame_done` is produced; drawers may still be running and must be reset by the same `resetn`.
- Let E be the edge at which `frame_start` is sampled in IDLE:
  - `busy` and `en1` are high in cycle E+1 (START1).
  - RUN1 begins at E+2.
- Pixel latency: the drawer's `we` sampled at edge N produces `vga_plot` high during cycle N+1.
- `done1` sampled at edge D causes START2 (`en2`=1) in cycle D+1 and RUN2 from D+2.
- `done2` sampled at edge D causes FDONE (`frame_done`=1) in cycle D+1 and IDLE (`busy`=0) at D+2.
- Minimum frame length with immediate dones: 6 cycles from E to the return to IDLE.
- A `frame_start` that coincides with the FDONE cycle counts as an overrun.

## Test plan
- Reset, then `frame_start`, with model drawers each emitting 10 in-range pixels and then `done` -> `en1` then `en2` pulse for exactly 1 cycle each; 20 `vga_plot` pulses with matching coordinates one cycle late; `pixel_count`=20; `frame_done` pulses once; `busy` falls.
- Hook 1 emits x=319 and x=320, y=239 and y=240 -> only (319,239) is plotted; `pixel_count`=1.
- Hook 2 never asserts `done` -> exactly `TIMEOUT` cycles in RUN2, then `timeout_err`=1 and `frame_done` pulses; a second frame leaves `timeout_err` at 1.
- `frame_start` pulsed during RUN1 -> ignored, `overrun_err`=1, only one `frame_done`.
- `we1`=1 together with `done1`=1 -> the pixel is plotted and `en2` pulses in the next cycle; toggling `we2` during RUN1 produces no plot.
- `resetn` dropped asynchronously mid-RUN2 -> all outputs are 0 within the same cycle; a new `frame_start` then runs a clean frame.
